// File: rtl/arb_defs.sv
// Shared definitions for the memory arbiter.
// Holds the FSM state encoding, the default abort timeout and the wait counter
// width. It also provides a helper that maps a timeout value onto the counter's
// terminal value.
package arb_defs;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StInst = 2'd2
  } arb_state_e;

  // Longest wait for mem_ack before an access is aborted.
  localparam int unsigned DefaultTimeout = 255;

  // Wide enough for any timeout in 1..255.
  localparam int unsigned CntW = 8;

  // The counter value at which the next ack-less cycle hits the limit.
  function automatic logic [CntW-1:0] cnt_last(input int unsigned limit);
    return CntW'(limit - 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-cycle counter for one outstanding memory access.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears the count
//   clr_i - clear the count (a new grant)
//   en_i  - count this cycle (busy and no ack)
//   tc_o  - terminal count: this counted cycle reaches Limit
module wait_counter
  import arb_defs::*;
#(
  parameter int unsigned Limit = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CntW-1:0] Last = cnt_last(Limit);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count becomes Limit on this edge, so the access is aborted now.
  assign tc_o = en_i & (count_q == Last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto a single shared memory port.
// Ports:
//   clk, rst                - clock and synchronous active-high reset
//   inst_req/addr           - fetch request level and word address
//   inst_rdata/ready        - fetched word and its one-cycle completion pulse
//   data_req/wr/addr/wdata/wen - MEM-stage request and command
//   data_rdata/ready        - load data and its one-cycle completion pulse
//   bus_err                 - pulses with a ready when that access timed out
//   mem_req/wr/addr/wdata/wen - registered shared-port command
//   mem_ack/rdata           - shared-port accept strobe and read data
//   stall                   - combinational pipeline stall
module mem_arbiter
  import arb_defs::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wen,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  arb_state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wen_q, mem_wen_d;
  logic              inst_ready_q, inst_ready_d;
  logic              data_ready_q, data_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic cnt_clr, cnt_en, cnt_tc;
  logic data_elig, inst_elig;

  // A requester whose ready pulses this cycle is completing, not requesting.
  assign data_elig = data_req & ~data_ready_q;
  assign inst_elig = inst_req & ~inst_ready_q;

  wait_counter #(
    .Limit (TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = mem_wen_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    bus_err_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mem_ack is ignored here: nothing is outstanding.
        if (data_elig) begin
          state_d     = StData;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_wen_d   = data_wen;
          cnt_clr     = 1'b1;
        end else if (inst_elig) begin
          state_d     = StInst;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          mem_wen_d   = '0;
          cnt_clr     = 1'b1;
        end
      end

      StData: begin
        if (mem_ack) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          data_ready_d = 1'b1;
          if (!mem_wr_q) begin
            data_rdata_d = mem_rdata;
          end
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d      = StIdle;
            mem_req_d    = 1'b0;
            data_ready_d = 1'b1;
            bus_err_d    = 1'b1;
            data_rdata_d = '0;
          end
        end
      end

      StInst: begin
        if (mem_ack) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          inst_ready_d = 1'b1;
          inst_rdata_d = mem_rdata;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d      = StIdle;
            mem_req_d    = 1'b0;
            inst_ready_d = 1'b1;
            bus_err_d    = 1'b1;
            inst_rdata_d = '0;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      bus_err_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      bus_err_q    <= bus_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign inst_ready = inst_ready_q;
  assign data_ready = data_ready_q;
  assign bus_err    = bus_err_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign stall = (inst_req & ~inst_ready_q) | (data_req & ~data_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        bus_err;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(
    .TIMEOUT (4),
    .ADDR_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wen   (data_wen),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wen = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    n_cmp++;
    if ({mem_req, mem_wr, mem_wen, inst_ready, data_ready, bus_err, stall} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0",
               {mem_req, mem_wr, mem_wen, inst_ready, data_ready, bus_err, stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h irdata %h drdata %h want all 0",
               mem_addr, mem_wdata, inst_rdata, data_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_data_read();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h100; data_wen = 4'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL rd_stall_c0: got %b want 1", stall);
    end
    tick(); // cycle 1
    n_cmp++;
    if ({mem_req, mem_wr, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL rd_cmd_c1: req %b wr %b addr %h want 1 0 00000100", mem_req, mem_wr, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); // cycle 2
    mem_ack = 1'b0;
    n_cmp++;
    if ({data_ready, bus_err, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL rd_ready_c2: rdy %b err %b req %b want 1 0 0", data_ready, bus_err, mem_req);
    end
    n_cmp++;
    if (data_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", data_rdata);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL rd_stall_c2: got %b want 0", stall);
    end
    data_req = 1'b0;
    tick(); // cycle 3
    n_cmp++;
    if ({data_ready, mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL rd_idle_c3: rdy %b req %b want 0 0", data_ready, mem_req);
    end
  endtask

  task automatic test_priority();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
    inst_req = 1'b1; inst_addr = 32'h300;
    tick(); // cycle 1: data wins
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL pri_data_first: req %b addr %h want 1 00000200", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick(); // cycle 2: data_ready, inst granted here while data_req still high
    mem_ack = 1'b0;
    n_cmp++;
    if ({data_ready, inst_ready, stall} !== 3'b101) begin
      n_fail++;
      $display("FAIL pri_c2: drdy %b irdy %b stall %b want 1 0 1", data_ready, inst_ready, stall);
    end
    tick(); // cycle 3: inst access on the bus, not a repeat of the data access
    data_req = 1'b0;
    n_cmp++;
    if ({mem_req, mem_wr, mem_wen, mem_addr} !== {1'b1, 1'b0, 4'b0, 32'h300}) begin
      n_fail++;
      $display("FAIL pri_inst_cmd: req %b wr %b wen %b addr %h want 1 0 0000 00000300",
               mem_req, mem_wr, mem_wen, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    tick(); // cycle 4
    mem_ack = 1'b0;
    n_cmp++;
    if ({inst_ready, data_ready, inst_rdata} !== {1'b1, 1'b0, 32'h22222222}) begin
      n_fail++;
      $display("FAIL pri_inst_done: irdy %b drdy %b rdata %h want 1 0 22222222",
               inst_ready, data_ready, inst_rdata);
    end
    inst_req = 1'b0;
    tick(); // cycle 5
    tick(); // cycle 6
    n_cmp++;
    if ({mem_req, data_ready, inst_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL pri_no_dup: req %b drdy %b irdy %b want 0 0 0", mem_req, data_ready, inst_ready);
    end
  endtask

  task automatic test_write();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h40;
    data_wdata = 32'h12345678; data_wen = 4'b0011;
    tick(); // cycle 1
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_wen, data_ready} !==
          {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_hold_c%0d: req %b wr %b addr %h wdata %h wen %b rdy %b want 1 1 40 12345678 0011 0",
                 i, mem_req, mem_wr, mem_addr, mem_wdata, mem_wen, data_ready);
      end
      if (i == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      end
      tick();
    end
    mem_ack = 1'b0; // cycle 5
    n_cmp++;
    if ({data_ready, bus_err, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_done: rdy %b err %b req %b want 1 0 0", data_ready, bus_err, mem_req);
    end
    n_cmp++;
    if (data_rdata !== 32'h11111111) begin
      n_fail++; $display("FAIL wr_rdata_kept: got %h want 11111111", data_rdata);
    end
    data_req = 1'b0; data_wr = 1'b0; data_wen = 4'b0; data_wdata = '0;
    tick();
  endtask

  task automatic test_timeout();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h500;
    tick(); // cycle 1
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({mem_req, data_ready, bus_err} !== 3'b100) begin
        n_fail++;
        $display("FAIL to_wait_c%0d: req %b rdy %b err %b want 1 0 0", i, mem_req, data_ready, bus_err);
      end
      tick();
    end
    // cycle 5
    n_cmp++;
    if ({mem_req, data_ready, bus_err} !== 3'b011) begin
      n_fail++;
      $display("FAIL to_abort: req %b rdy %b err %b want 0 1 1", mem_req, data_ready, bus_err);
    end
    n_cmp++;
    if (data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_rdata: got %h want 0", data_rdata);
    end
    data_req = 1'b0;
    tick(); // cycle 6
    n_cmp++;
    if ({mem_req, data_ready, bus_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL to_after: req %b rdy %b err %b want 0 0 0", mem_req, data_ready, bus_err);
    end
  endtask

  task automatic test_reset_mid();
    inst_req = 1'b1; inst_addr = 32'h600;
    tick(); // cycle 1: INST
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      n_fail++; $display("FAIL rstm_busy: req %b addr %h want 1 00000600", mem_req, mem_addr);
    end
    rst = 1'b1;
    tick(); // cycle 2
    rst = 1'b0;
    n_cmp++;
    if ({mem_req, inst_ready, inst_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstm_abandon: req %b irdy %b rdata %h want 0 0 0", mem_req, inst_ready, inst_rdata);
    end
    inst_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick(); // cycle 3: stray ack was sampled in IDLE
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, inst_ready, data_ready, inst_rdata} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL rstm_stray_ack: req %b irdy %b drdy %b rdata %h want 0 0 0 0",
               mem_req, inst_ready, data_ready, inst_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    inst_req = 1'b1; inst_addr = 32'h0;
    tick(); // cycle 1
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL b2b_first: req %b addr %h want 1 00000000", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA0A0A0A0;
    tick(); // cycle 2
    mem_ack = 1'b0;
    if (inst_ready === 1'b1) pulses++;
    n_cmp++;
    if (inst_rdata !== 32'hA0A0A0A0) begin
      n_fail++; $display("FAIL b2b_rdata0: got %h want a0a0a0a0", inst_rdata);
    end
    inst_addr = 32'h4; // next fetch, request held
    tick(); // cycle 3: ready was high last cycle, so no grant happened there
    if (inst_ready === 1'b1) pulses++;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: req %b want 0", mem_req);
    end
    tick(); // cycle 4
    if (inst_ready === 1'b1) pulses++;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL b2b_second: req %b addr %h want 1 00000004", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hB0B0B0B0;
    tick(); // cycle 5
    mem_ack = 1'b0;
    if (inst_ready === 1'b1) pulses++;
    n_cmp++;
    if (inst_rdata !== 32'hB0B0B0B0) begin
      n_fail++; $display("FAIL b2b_rdata1: got %h want b0b0b0b0", inst_rdata);
    end
    inst_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_ready === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_priority();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles a granted access waits for mem_ack before abort (1..255).
REQ-002 Parameter: ADDR_W, 32, address width of all address ports.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed:
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request level, held until inst_ready
- inst_addr  in  ADDR_W  fetch word address
- inst_rdata  out  32  fetched word, valid with inst_ready
- inst_ready  out  1  one-cycle completion pulse, fetch side
- data_req  in  1  MEM-stage request level, held until data_ready
- data_wr  in  1  1=write, 0=read
- data_addr  in  ADDR_W  data address
- data_wdata  in  32  store data
- data_wen  in  4  byte enables for writes
- data_rdata  out  32  load data, valid with data_ready
- data_ready  out  1  one-cycle completion pulse, data side
- bus_err  out  1  pulses with a ready when that access timed out
- mem_req  out  1  shared-port request
- mem_wr, mem_addr, mem_wdata, mem_wen  out  1/ADDR_W/32/4  shared-port command
- mem_ack  in  1  one-cycle accept/complete strobe; mem_rdata valid same cycle
- mem_rdata  in  32  shared-port read data
- stall  out  1  pipeline stall request

Function
REQ-004 FSM states SHALL be IDLE, DATA, INST; grant decisions SHALL be made only in IDLE.
REQ-005 In IDLE, data_req SHALL have fixed priority over inst_req; a requester whose ready is high in that cycle is ineligible.
REQ-006 On grant, the command (addr, wr, wdata, wen) SHALL be latched; inst grants force mem_wr=0, mem_wen=0.
REQ-007 mem_req and the latched command SHALL be registered and held stable from the cycle after grant until the cycle mem_ack is sampled high, inclusive.
REQ-008 On mem_ack in DATA/INST: the matching ready SHALL pulse the next cycle, rdata SHALL register mem_rdata (data reads and fetches; unchanged on writes), FSM SHALL return to IDLE.
REQ-009 Minimum latency: grant at cycle 0, mem_req high cycle 1, ack cycle 1, ready cycle 2; next grant evaluated cycle 2.
REQ-010 A wait counter SHALL clear on grant and increment each DATA/INST cycle with mem_ack low.
REQ-011 When the counter reaches TIMEOUT with no ack: mem_req drops, the ready and bus_err pulse together the next cycle, rdata SHALL be 0, FSM returns to IDLE.
REQ-012 mem_ack sampled in IDLE SHALL be ignored.
REQ-013 stall SHALL be combinational: (inst_req & ~inst_ready) | (data_req & ~data_ready).
REQ-014 Requests dropped before ready are a protocol violation; a granted access SHALL still complete and pulse ready.

Reset
REQ-015 On rst: state IDLE, mem_req=0, mem_wr=0, mem_wen=0, mem_addr=0, mem_wdata=0, inst_ready=0, data_ready=0, bus_err=0, inst_rdata=0, data_rdata=0, counter=0.
REQ-016 rst mid-access SHALL abandon it without ready pulse; mem_req low from the next cycle.

Structure
REQ-017 State encoding and default TIMEOUT SHALL live in shared package arb_defs.
REQ-018 The timeout counter SHALL be sub-module wait_counter (clear, enable, terminal-count output).

Verification
REQ-019 Data read 0x100 alone, ack on first mem_req cycle, mem_rdata=0xDEADBEEF -> data_ready at cycle 2, data_rdata=0xDEADBEEF, stall low at cycle 2.
REQ-020 inst_req and data_req rise same cycle -> data served first, inst granted in data_ready cycle, no duplicate data access.
REQ-021 Data write addr 0x40, wdata 0x12345678, wen 4'b0011, ack after 3 wait cycles -> mem_* stable 4 cycles, data_rdata unchanged.
REQ-022 TIMEOUT=4, never ack -> mem_req high 4 cycles, then data_ready+bus_err pulse, data_rdata=0.
REQ-023 rst asserted while in INST -> mem_req low next cycle, no inst_ready; subsequent stray mem_ack ignored.
REQ-024 Back-to-back fetches 0x0,0x4 -> two distinct transactions, inst_ready pulses exactly twice.
